mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. Owns the HI/LO registers.
- The hazard unit issues stall/flush commands; this block is the hazard source that requests them. It raises a stall request while busy, and the hazard unit folds that request into stallF/stallD/flushE.
- Executes MULT/MULTU/DIV/DIVU, MTHI/MTLO; provides HI/LO to MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. The iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- startE  input  1  an MDU op (mult/div family) is in EX this cycle
- mdopE  input  3  op code from the shared package: MULT, MULTU, DIV, DIVU, MTHI, MTLO
- flushE  input  1  EX bubble from the hazard unit; suppresses startE
- srcaE  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- srcbE  input  WIDTH  rt operand (divisor / multiplier)
- hilo_useD  input  1  instruction in ID is MFHI/MFLO or any MDU op
- busy  output  1  iteration in progress
- mdu_stallD  output  1  busy && hilo_useD; feeds the hazard unit's stall OR
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, busy=0, hi=0, lo=0, counter=0. Any in-flight op is discarded.
- States and transitions:
  - IDLE: accepted = startE && !flushE && !busy.
    - MTHI/MTLO: hi<=srcaE or lo<=srcaE at that edge; stay in IDLE; 1-cycle op.
    - Mult/div op: latch the operand magnitudes (absolute values for signed ops, raw for unsigned), the result sign flags and the op; counter<=0; go to RUN.
  - RUN: one radix-2 step per cycle; counter increments. When counter==WIDTH-1, go to FIX.
    - Multiply: shift-add into a 2*WIDTH accumulator.
    - Divide: restoring divide; one quotient bit per cycle.
  - FIX: apply the sign correction, write hi/lo at this edge, go to IDLE.
- Latency: busy is high from the cycle after acceptance through FIX, i.e. WIDTH+1 cycles (33 at default). New hi/lo values are visible in the cycle after FIX.
- busy is 0 in IDLE and 1 in RUN and FIX; it is a registered state decode.
- mdu_stallD is combinational. It holds ID, and the hazard unit bubbles EX.
- Results:
  - MULT/MULTU: {hi,lo} = 64-bit product. Signed product = two's-complement negation of the magnitude product when sign(a)^sign(b).
  - DIV/DIVU: lo=quotient, hi=remainder.
    - Signed division truncates toward zero: quotient negated if sign(a)^sign(b); remainder takes the sign of the dividend.
    - Divisor 0: lo=all ones, hi=dividend (raw srcaE), for both signed and unsigned.
    - DIV -2^(W-1) / -1: lo=0x80000000, hi=0. The magnitude path yields this naturally.
- Boundary rules:
  - startE while busy: ignored and hi/lo untouched. The hazard unit guarantees this never happens; the bench asserts it.
  - startE with flushE: ignored, including MTHI/MTLO.
  - Reads of hi/lo during busy: return the old values. The stall prevents MFHI/MFLO from consuming them.
  - Back-to-back op: can be accepted in the IDLE cycle right after FIX.

Decomposition:
- Shared package mdu_pkg:
  - typedef enum logic [2:0] mdop_t {MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO}
  - state enum {S_IDLE, S_RUN, S_FIX}
- One sub-module: mdu_step. It is the combinational single-iteration datapath: add/shift for multiply, trial-subtract for divide. It is instantiated once and driven by the FSM in mdu_iter.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy for 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=100. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- hilo_useD=1 held during DIVU 10/3 -> mdu_stallD=1 for exactly 33 cycles, then 0 with lo=3, hi=1.
- startE with flushE=1 (MTLO 0x1234) -> lo unchanged and busy stays 0. MTHI 0x55 alone -> hi=0x55 next cycle.
- reset asserted at RUN cycle 10 of MULT -> busy, hi, lo = 0 immediately. A following DIVU 9/4 completes normally: lo=2, hi=1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared opcode and state types for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } mdop_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic is_signed_op(input mdop_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input mdop_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_muldiv_op(input mdop_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// The accumulator holds {upper, lower}; the multiplier / dividend lives in the lower half.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Single-step datapath; trial[WIDTH] set means the partial remainder was below the divisor.
  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    trial   = shifted - {1'b0, opb};
    acc_out = acc_in;
    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_in[0]) begin
        acc_out = {sum, acc_in[WIDTH-1:1]};
      end else begin
        acc_out = {1'b0, acc_in[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit owning HI/LO; requests an ID stall while busy.
// Operands are reduced to magnitudes on entry and the sign is restored in the FIX cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  mdop_t            mdopE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hilo_useD,
  output logic             busy,
  output logic             mdu_stallD,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = 2 * WIDTH;

  state_t          state;
  logic [CW-1:0]   count;
  logic [DW-1:0]   acc;
  logic [DW-1:0]   acc_next;
  logic [WIDTH-1:0] opb;
  logic            is_div;
  logic            neg_q;
  logic            neg_r;
  logic            div_zero;

  logic            accepted;
  logic            sa;
  logic            sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [DW-1:0]   prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_in  (acc),
    .opb     (opb),
    .acc_out (acc_next)
  );

  // Acceptance, operand magnitudes and sign-corrected results.
  always_comb begin
    accepted = startE && !flushE && !busy && (state == S_IDLE);
    sa       = is_signed_op(mdopE) && srcaE[WIDTH-1];
    sb       = is_signed_op(mdopE) && srcbE[WIDTH-1];
    mag_a    = sa ? (WIDTH'(0) - srcaE) : srcaE;
    mag_b    = sb ? (WIDTH'(0) - srcbE) : srcbE;
    prod_fix = neg_q ? (DW'(0) - acc) : acc;
    quo_fix  = neg_q ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix  = neg_r ? (WIDTH'(0) - acc[DW-1:WIDTH]) : acc[DW-1:WIDTH];
  end

  assign mdu_stallD = busy && hilo_useD;

  // Control FSM with registered busy and HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
      count    <= {CW{1'b0}};
      acc      <= {DW{1'b0}};
      opb      <= {WIDTH{1'b0}};
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accepted) begin
            case (mdopE)
              MD_MTHI: hi <= srcaE;
              MD_MTLO: lo <= srcaE;
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                acc      <= {{WIDTH{1'b0}}, is_div_op(mdopE) ? mag_a : mag_b};
                opb      <= is_div_op(mdopE) ? mag_b : mag_a;
                is_div   <= is_div_op(mdopE);
                neg_q    <= sa ^ sb;
                neg_r    <= sa;
                div_zero <= (srcbE == {WIDTH{1'b0}});
                count    <= {CW{1'b0}};
                busy     <= 1'b1;
                state    <= S_RUN;
              end
              default: begin
              end
            endcase
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          // A zero divisor leaves the raw dividend in the remainder after sign restore.
          if (is_div) begin
            lo <= div_zero ? {WIDTH{1'b1}} : quo_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[DW-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: expected HI/LO pushed at issue, popped when the op retires.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        startE;
  mdop_t       mdopE;
  logic        flushE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        hilo_useD;
  logic        busy;
  logic        mdu_stallD;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .startE(startE), .mdopE(mdopE), .flushE(flushE),
    .srcaE(srcaE), .srcbE(srcbE), .hilo_useD(hilo_useD), .busy(busy),
    .mdu_stallD(mdu_stallD), .hi(hi), .lo(lo)
  );

  function automatic logic [63:0] model(input mdop_t op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] h, input logic [31:0] l);
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    int signed qa;
    int signed qb;
    logic [31:0] q;
    logic [31:0] r;
    sa64 = $signed(a);
    sb64 = $signed(b);
    qa = $signed(a);
    qb = $signed(b);
    case (op)
      MD_MULT:  return sa64 * sb64;
      MD_MULTU: return {32'd0, a} * {32'd0, b};
      MD_DIVU:  begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      MD_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = qa / qb;
        r = qa % qb;
        return {r, q};
      end
      MD_MTHI: return {a, l};
      MD_MTLO: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  // Caller sits at a negedge; the op is presented across exactly one rising edge.
  task automatic start_op(input mdop_t op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    logic [63:0] r;
    checks++;
    if (busy && !fl) begin
      errors++;
      $display("FAIL start_while_busy: busy=%b required 0", busy);
    end
    startE = 1'b1; flushE = fl; mdopE = op; srcaE = a; srcbE = b;
    if (!fl) begin
      r = model(op, a, b, model_hi, model_lo);
      model_hi = r[63:32];
      model_lo = r[31:0];
      sb_q.push_back(r);
    end
    @(negedge clk);
    startE = 1'b0; flushE = 1'b0; mdopE = MD_NONE;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; startE = 1'b0; flushE = 1'b0; hilo_useD = 1'b0;
    mdopE = MD_NONE; srcaE = 32'd0; srcbE = 32'd0;
    model_hi = 32'd0; model_lo = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, mdu_stallD, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b stall=%b hi=%h lo=%h required all 0", busy, mdu_stallD, hi, lo);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu_max;
    int n;
    logic [63:0] exp;
    start_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_busy(n);
    exp = sb_q.pop_front();
    checks++;
    if (n !== 33) begin
      errors++;
      $display("FAIL multu_latency: busy cycles %0d required 33", n);
    end
    checks++;
    if ({hi, lo} !== exp || {hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL multu_max: got %h required %h", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    end
  endtask

  task automatic test_signed_and_corner;
    mdop_t       ops[4]  = '{MD_MULT, MD_DIV, MD_DIVU, MD_DIV};
    logic [31:0] as[4]   = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
    logic [31:0] bs[4]   = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [63:0] cst[4]  = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFD,
                             64'h0000_0064_FFFF_FFFF, 64'h0000_0000_8000_0000};
    int n;
    logic [63:0] exp;
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], as[i], bs[i], 1'b0);
      wait_busy(n);
      exp = sb_q.pop_front();
      checks++;
      if ({hi, lo} !== exp || {hi, lo} !== cst[i]) begin
        errors++;
        $display("FAIL corner_%0d: got %h required %h", i, {hi, lo}, cst[i]);
      end
    end
  endtask

  task automatic test_stall;
    int n;
    logic [63:0] exp;
    logic [63:0] old;
    logic held;
    old = {hi, lo};
    held = 1'b1;
    hilo_useD = 1'b1;
    start_op(MD_DIVU, 32'd10, 32'd3, 1'b0);
    n = 0;
    while (mdu_stallD && n < 200) begin
      if ({hi, lo} !== old) held = 1'b0;
      n++;
      @(negedge clk);
    end
    hilo_useD = 1'b0;
    exp = sb_q.pop_front();
    checks++;
    if (n !== 33) begin
      errors++;
      $display("FAIL stall_cycles: stall high %0d cycles required 33", n);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL hilo_hold_while_busy: hi/lo changed during busy, required %h", old);
    end
    checks++;
    if ({hi, lo} !== exp || {hi, lo} !== 64'h0000_0001_0000_0003) begin
      errors++;
      $display("FAIL divu_10_3: got %h required %h", {hi, lo}, 64'h0000_0001_0000_0003);
    end
  endtask

  task automatic test_flush_mt;
    logic [31:0] old_lo;
    logic [63:0] exp;
    old_lo = lo;
    start_op(MD_MTLO, 32'h0000_1234, 32'd0, 1'b1);
    checks++;
    if (lo !== old_lo || busy !== 1'b0) begin
      errors++;
      $display("FAIL flushed_mtlo: lo=%h busy=%b required lo=%h busy=0", lo, busy, old_lo);
    end
    start_op(MD_MTHI, 32'h0000_0055, 32'd0, 1'b0);
    exp = sb_q.pop_front();
    checks++;
    if ({hi, lo} !== exp || hi !== 32'h0000_0055 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b required %h busy=0", hi, lo, busy, exp);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [63:0] exp;
    start_op(MD_MULT, 32'd12345, 32'hFFFF_FD5A, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, hi, lo} !== 65'd0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b hi=%h lo=%h required all 0", busy, hi, lo);
    end
    sb_q.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    start_op(MD_DIVU, 32'd9, 32'd4, 1'b0);
    wait_busy(n);
    exp = sb_q.pop_front();
    checks++;
    if ({hi, lo} !== exp || {hi, lo} !== 64'h0000_0001_0000_0002 || n !== 33) begin
      errors++;
      $display("FAIL divu_after_reset: got %h in %0d cycles required %h in 33", {hi, lo}, n, 64'h0000_0001_0000_0002);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    mdop_t op;
    logic [31:0] v[2];
    logic [63:0] exp;
    for (int i = 0; i < 16; i++) begin
      op = mdop_t'($urandom_range(1, 6));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 4))
          0: v[k] = 32'd0;
          1: v[k] = 32'h8000_0000;
          2: v[k] = 32'hFFFF_FFFF;
          default: v[k] = $urandom;
        endcase
      end
      start_op(op, v[0], v[1], 1'b0);
      wait_busy(n);
      exp = sb_q.pop_front();
      checks++;
      if ({hi, lo} !== exp || n !== (is_muldiv_op(op) ? 33 : 0)) begin
        errors++;
        $display("FAIL b2b_%0d op=%0d a=%h b=%h: got %h in %0d cycles required %h", i, op, v[0], v[1], {hi, lo}, n, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed_and_corner();
    test_stall();
    test_flush_mt();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
